// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for serial_subtractor.
// Handshake: start is sampled only while busy is low. done pulses for one cycle when diff/bout update.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic [1:0]       dbg_state;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout, dbg_state
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout, dbg_state
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first, through one full-subtract cell with a registered borrow.
// Takes WIDTH shift cycles plus one DONE cycle per operation.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             a0, b0;
    logic             bit_diff;
    logic             bit_borrow;
    logic [WIDTH-1:0] work_shift;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_SHIFT;
            S_SHIFT: if (cnt_q == LAST) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy      = (state_q != S_IDLE);
        bus.done      = (state_q == S_DONE);
        bus.diff      = diff_q;
        bus.bout      = bout_q;
        bus.dbg_state = state_q;
    end

    // Full-subtract cell on the current LSBs; the difference bit enters work_q at the MSB.
    always_comb begin
        a0         = a_sr_q[0];
        b0         = b_sr_q[0];
        bit_diff   = a0 ^ b0 ^ br_q;
        bit_borrow = (~a0 & b0) | (~(a0 ^ b0) & br_q);
        work_shift = {bit_diff, work_q[WIDTH-1:1]};
    end

    always_comb begin
        a_sr_d = a_sr_q;
        b_sr_d = b_sr_q;
        work_d = work_q;
        diff_d = diff_q;
        br_d   = br_q;
        bout_d = bout_q;
        cnt_d  = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_sr_d = bus.a;
                    b_sr_d = bus.b;
                    br_d   = bus.bin;
                    cnt_d  = '0;
                end
            end
            S_SHIFT: begin
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                work_d = work_shift;
                br_d   = bit_borrow;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    diff_d = work_shift;
                    bout_d = bit_borrow;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr_q <= '0;
            b_sr_q <= '0;
            work_q <= '0;
            diff_q <= '0;
            br_q   <= 1'b0;
            bout_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            a_sr_q <= a_sr_d;
            b_sr_q <= b_sr_d;
            work_q <= work_d;
            diff_q <= diff_d;
            br_q   <= br_d;
            bout_q <= bout_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: WIDTH=8 directed/handshake scenarios and WIDTH=2 exhaustive.
module tb_serial_subtractor;
    localparam int W  = 8;
    localparam int W2 = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(W))  if8 ();
    serial_subtractor_if #(.WIDTH(W2)) if2 ();

    serial_subtractor #(.WIDTH(W))  dut8 (.clk(clk), .rst(rst), .bus(if8.slave));
    serial_subtractor #(.WIDTH(W2)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

    int checks = 0;
    int errors = 0;
    int done_cnt8 = 0;
    int done_cnt2 = 0;

    logic [W:0]   exp_q[$];
    logic [W2:0]  exp2_q[$];
    logic [W:0]   mexp8;
    logic [W2:0]  mexp2;
    logic [W-1:0] last8 = '0;

    // Scoreboards: each done pulse pops one expected {bout, diff}.
    always @(negedge clk) begin
        if (if8.done === 1'b1) begin
            done_cnt8++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL w8_unexpected_done: got diff=%h bout=%b, required no done", if8.diff, if8.bout);
            end else begin
                mexp8 = exp_q.pop_front();
                if ({if8.bout, if8.diff} !== mexp8) begin
                    errors++;
                    $display("FAIL w8_result: got bout=%b diff=%h, required bout=%b diff=%h",
                             if8.bout, if8.diff, mexp8[W], mexp8[W-1:0]);
                end
            end
        end
        if (if2.done === 1'b1) begin
            done_cnt2++;
            checks++;
            if (exp2_q.size() == 0) begin
                errors++;
                $display("FAIL w2_unexpected_done: got diff=%h bout=%b, required no done", if2.diff, if2.bout);
            end else begin
                mexp2 = exp2_q.pop_front();
                if ({if2.bout, if2.diff} !== mexp2) begin
                    errors++;
                    $display("FAIL w2_result: got bout=%b diff=%h, required bout=%b diff=%h",
                             if2.bout, if2.diff, mexp2[W2], mexp2[W2-1:0]);
                end
            end
        end
    end

    function automatic logic [W:0] model8(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        return {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start8(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        if8.a     = a;
        if8.b     = b;
        if8.bin   = bin;
        if8.start = 1'b1;
        exp_q.push_back(model8(a, b, bin));
        tick();
        if8.start = 1'b0;
    endtask

    task automatic wait8(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < W + 6) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: %0d results pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({if8.busy, if8.done, if8.bout, if8.diff} !== {3'b000, {W{1'b0}}}) begin
                errors++;
                $display("FAIL reset_idle: got busy=%b done=%b bout=%b diff=%h, required all 0",
                         if8.busy, if8.done, if8.bout, if8.diff);
            end
        end
        tick();
    endtask

    task automatic test_basic();
        logic [W:0] r;
        r = model8(8'd200, 8'd55, 1'b0);
        start8(8'd200, 8'd55, 1'b0);
        for (int e = 0; e <= 10; e++) begin
            @(negedge clk);
            checks++;
            if (if8.busy !== (e <= 8)) begin
                errors++;
                $display("FAIL basic_busy: cycle after edge %0d got %b, required %b", e, if8.busy, (e <= 8));
            end
            checks++;
            if (if8.done !== (e == 8)) begin
                errors++;
                $display("FAIL basic_done: cycle after edge %0d got %b, required %b", e, if8.done, (e == 8));
            end
            checks++;
            if (if8.diff !== ((e >= 8) ? 8'h91 : last8)) begin
                errors++;
                $display("FAIL basic_diff: cycle after edge %0d got %h, required %h",
                         e, if8.diff, (e >= 8) ? 8'h91 : last8);
            end
            tick();
        end
        last8 = r[W-1:0];
    endtask

    task automatic test_reset_mid();
        int d0;
        start8(8'd200, 8'd55, 1'b0);
        repeat (3) tick();
        rst = 1'b1;
        #1;
        checks++;
        if ({if8.busy, if8.done, if8.bout, if8.diff, if8.dbg_state} !== {3'b000, {W{1'b0}}, 2'b00}) begin
            errors++;
            $display("FAIL reset_mid: got busy=%b done=%b bout=%b diff=%h state=%0d, required all 0",
                     if8.busy, if8.done, if8.bout, if8.diff, if8.dbg_state);
        end
        exp_q.delete();
        d0 = done_cnt8;
        #2;
        rst = 1'b0;
        repeat (12) tick();
        checks++;
        if (done_cnt8 != d0) begin
            errors++;
            $display("FAIL reset_mid_no_done: got %0d done pulses, required 0", done_cnt8 - d0);
        end
        last8 = '0;
    endtask

    task automatic test_borrow();
        logic [W-1:0] va[4]  = '{8'd5,  8'h00, 8'hFF, 8'h80};
        logic [W-1:0] vb[4]  = '{8'd10, 8'h00, 8'hFF, 8'h7F};
        logic         vc[4]  = '{1'b0,  1'b1,  1'b1,  1'b1};
        logic [W-1:0] ed[4]  = '{8'hFB, 8'hFF, 8'hFF, 8'h00};
        logic         eb[4]  = '{1'b1,  1'b1,  1'b1,  1'b0};
        for (int i = 0; i < 4; i++) begin
            start8(va[i], vb[i], vc[i]);
            wait8("borrow");
            @(negedge clk);
            checks++;
            if ({if8.bout, if8.diff} !== {eb[i], ed[i]}) begin
                errors++;
                $display("FAIL borrow_const: vector %0d got bout=%b diff=%h, required bout=%b diff=%h",
                         i, if8.bout, if8.diff, eb[i], ed[i]);
            end
            last8 = ed[i];
            tick();
        end
    endtask

    task automatic test_ignore_start();
        int d0;
        logic [W-1:0] a, b;
        logic [W:0] r;
        d0 = done_cnt8;
        a = W'($urandom_range(0, 255));
        b = W'($urandom_range(0, 255));
        r = model8(a, b, 1'b0);
        start8(a, b, 1'b0);
        for (int i = 1; i <= 9; i++) begin
            if8.start = 1'($urandom_range(0, 1));
            if8.a     = W'($urandom_range(0, 255));
            if8.b     = W'($urandom_range(0, 255));
            if8.bin   = 1'($urandom_range(0, 1));
            tick();
        end
        if8.start = 1'b0;
        repeat (4) tick();
        checks++;
        if (done_cnt8 - d0 != 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL ignore_start: got %0d done pulses (%0d pending), required 1",
                     done_cnt8 - d0, exp_q.size());
            exp_q.delete();
        end
        last8 = r[W-1:0];
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] res[4];
        logic [W:0]   r;
        logic [W-1:0] want;
        int d0;
        d0 = done_cnt8;
        for (int i = 0; i < 40; i++) begin
            if8.start = 1'b1;
            if8.a     = W'($urandom_range(0, 255));
            if8.b     = W'($urandom_range(0, 255));
            if8.bin   = 1'($urandom_range(0, 1));
            if (i % (W + 2) == 0) begin
                r = model8(if8.a, if8.b, if8.bin);
                exp_q.push_back(r);
                res[i / (W + 2)] = r[W-1:0];
            end
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (if8.done !== (i % (W + 2) == W)) begin
                errors++;
                $display("FAIL b2b_done: cycle after edge %0d got %b, required %b", i, if8.done, (i % (W + 2) == W));
            end
            want = (i >= W) ? res[(i - W) / (W + 2)] : last8;
            checks++;
            if (if8.diff !== want) begin
                errors++;
                $display("FAIL b2b_diff_hold: cycle after edge %0d got %h, required %h", i, if8.diff, want);
            end
        end
        if8.start = 1'b0;
        repeat (3) tick();
        checks++;
        if (done_cnt8 - d0 != 4 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_count: got %0d done pulses (%0d pending), required 4", done_cnt8 - d0, exp_q.size());
            exp_q.delete();
        end
        last8 = res[3];
    endtask

    task automatic test_exhaustive_w2();
        int n;
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                for (int c = 0; c < 2; c++) begin
                    if2.a     = W2'(a);
                    if2.b     = W2'(b);
                    if2.bin   = 1'(c);
                    if2.start = 1'b1;
                    exp2_q.push_back({1'b0, W2'(a)} - {1'b0, W2'(b)} - {{W2{1'b0}}, 1'(c)});
                    tick();
                    if2.start = 1'b0;
                    n = 0;
                    while (exp2_q.size() != 0 && n < 10) begin
                        tick();
                        n++;
                    end
                    checks++;
                    if (exp2_q.size() != 0) begin
                        errors++;
                        $display("FAIL w2_timeout: a=%0d b=%0d bin=%0d no done, required done", a, b, c);
                        exp2_q.delete();
                    end
                end
            end
        end
        checks++;
        if (done_cnt2 != 32) begin
            errors++;
            $display("FAIL w2_count: got %0d done pulses, required 32", done_cnt2);
        end
    endtask

    initial begin
        rst       = 1'b1;
        if8.start = 1'b0;
        if8.a     = '0;
        if8.b     = '0;
        if8.bin   = 1'b0;
        if2.start = 1'b0;
        if2.a     = '0;
        if2.b     = '0;
        if2.bin   = 1'b0;
        test_reset();
        test_basic();
        test_reset_mid();
        test_borrow();
        test_ignore_start();
        test_back_to_back();
        test_exhaustive_w2();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
